// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversampling constants and
// the clog2 helper used to size counters.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   localparam int DEF_OVERSAMPLE = 16;
   localparam int MID_TICK       = DEF_OVERSAMPLE / 2 - 1;

   // Never returns less than 1 so that counters always have at least one bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int mid_tick(input int oversample);
      return oversample / 2 - 1;
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive-side interface between the RX controller and the UART top-level.
// o_rx_done is a one-cycle valid with no ready: o_data and o_frame_err are
// stable from that cycle until the next o_rx_done, so a consumer may sample late.
interface uart_rx_ctrl_if
   import uart_pkg::*;
#(
   parameter int NB_DATA = 8
);
   logic [NB_DATA-1:0] o_data;
   logic               o_rx_done;
   logic               o_frame_err;
   logic               o_busy;
   state_t             o_dbg_state;

   modport master (
      output o_data,
      output o_rx_done,
      output o_frame_err,
      output o_busy,
      output o_dbg_state
   );

   modport slave (
      input o_data,
      input o_rx_done,
      input o_frame_err,
      input o_busy,
      input o_dbg_state
   );
endinterface

// File: rtl/uart_rx_ctrl_sync_2ff.sv
// Double-flop synchronizer for asynchronous inputs; resets to all ones so an
// idle-high line is not mistaken for an edge when reset releases.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: finds the start bit, samples data bits at mid-bit on the
// oversampling tick, checks the stop bit and strobes the received byte.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int NB_DATA    = 8,
   parameter int OVERSAMPLE = 16,
   parameter int SB_TICK    = 16
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_tick,
   input  logic           i_rx,
   uart_rx_ctrl_if.master rx_if
);

   localparam int TW = clog2((OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK);
   localparam int BW = clog2(NB_DATA);

   localparam logic [TW-1:0] C_MID      = TW'(mid_tick(OVERSAMPLE));
   localparam logic [TW-1:0] C_OS_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] C_SB_LAST  = TW'(SB_TICK - 1);
   localparam logic [BW-1:0] C_BIT_LAST = BW'(NB_DATA - 1);

   state_t             r_state,    w_state_next;
   logic [TW-1:0]      r_tick_cnt, w_tick_next;
   logic [BW-1:0]      r_bit_cnt,  w_bit_next;
   logic [NB_DATA-1:0] r_shift,    w_shift_next;
   logic [NB_DATA-1:0] r_data,     w_data_next;
   logic               r_frame_err, w_ferr_next;
   logic               r_rx_done,   w_done_next;
   logic               r_busy;
   logic               w_rx_s;

   sync_2ff #(.WIDTH(1)) u_rx_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_rx),
      .o_q     (w_rx_s)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_tick_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_frame_err <= 1'b0;
         r_rx_done   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_tick_cnt  <= w_tick_next;
         r_bit_cnt   <= w_bit_next;
         r_shift     <= w_shift_next;
         r_data      <= w_data_next;
         r_frame_err <= w_ferr_next;
         r_rx_done   <= w_done_next;
         r_busy      <= (w_state_next != ST_IDLE);
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_tick_next  = r_tick_cnt;
      w_bit_next   = r_bit_cnt;
      w_shift_next = r_shift;
      w_data_next  = r_data;
      w_ferr_next  = r_frame_err;
      w_done_next  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Start detection is level based and needs no tick.
            w_tick_next  = '0;
            w_bit_next   = '0;
            w_shift_next = '0;
            if (!w_rx_s) w_state_next = ST_START;
         end
         ST_START: begin
            if (i_tick) begin
               if (r_tick_cnt == C_MID) begin
                  w_tick_next  = '0;
                  w_bit_next   = '0;
                  w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  w_tick_next = r_tick_cnt + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (i_tick) begin
               if (r_tick_cnt == C_OS_LAST) begin
                  w_tick_next  = '0;
                  w_shift_next = {w_rx_s, r_shift[NB_DATA-1:1]};
                  if (r_bit_cnt == C_BIT_LAST) w_state_next = ST_STOP;
                  else                         w_bit_next   = r_bit_cnt + 1'b1;
               end else begin
                  w_tick_next = r_tick_cnt + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (i_tick) begin
               if (r_tick_cnt == C_SB_LAST) begin
                  w_tick_next  = '0;
                  w_data_next  = r_shift;
                  w_ferr_next  = ~w_rx_s;
                  w_done_next  = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_tick_next = r_tick_cnt + 1'b1;
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign rx_if.o_data      = r_data;
   assign rx_if.o_rx_done   = r_rx_done;
   assign rx_if.o_frame_err = r_frame_err;
   assign rx_if.o_busy      = r_busy;
   assign rx_if.o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: table of frames plus hand-written glitch,
// mid-frame reset, tick-freeze and break sequences, with a done-strobe scoreboard.
module tb_uart_rx_ctrl;
   import uart_pkg::*;

   // Tick period shortened from the 9600-baud divider to keep the run short;
   // the FSM only counts ticks, so frame timing in ticks is unchanged.
   localparam int TICK_DIV = 4;
   localparam int OS       = 16;
   localparam int LAT_CLKS = (9 * OS + OS / 2) * TICK_DIV;

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b1;
   logic i_tick  = 1'b0;
   logic i_rx    = 1'b1;
   logic tick_en = 1'b1;
   int   div     = 0;
   int   clk_cnt = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   done_clk = 0;
   int   start_clk = 0;
   logic prev_done = 1'b0;
   logic [8:0] exp_m;
   logic [8:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      int         stop_low;
      int         gap;
      logic       ferr;
   } vec_t;
   vec_t vecs[5];

   uart_rx_ctrl_if #(.NB_DATA(8)) rx_if ();

   uart_rx_ctrl #(
      .NB_DATA    (8),
      .OVERSAMPLE (OS),
      .SB_TICK    (16)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_tick  (i_tick),
      .i_rx    (i_rx),
      .rx_if   (rx_if)
   );

   // clock / reset-independent tick generator
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) begin
      clk_cnt <= clk_cnt + 1;
      if (!tick_en) begin
         i_tick <= 1'b0;
      end else if (div == TICK_DIV - 1) begin
         div    <= 0;
         i_tick <= 1'b1;
      end else begin
         div    <= div + 1;
         i_tick <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // driver tasks
   task automatic wait_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge i_clk);
         while (i_tick !== 1'b1) @(posedge i_clk);
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input int stop_low);
      i_rx = 1'b0;
      wait_ticks(OS);
      for (int b = 0; b < 8; b++) begin
         i_rx = data[b];
         wait_ticks(OS);
      end
      if (stop_low > 0) begin
         i_rx = 1'b0;
         wait_ticks(stop_low);
         i_rx = 1'b1;
         wait_ticks(OS - stop_low);
      end else begin
         i_rx = 1'b1;
         wait_ticks(OS);
      end
   endtask

   // scoreboard: every strobe must match the oldest pending frame
   always @(negedge i_clk) begin
      if (rx_if.o_rx_done) begin
         done_clk = clk_cnt;
         check("done_one_cycle", {31'd0, prev_done}, 32'd0);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe: got strobe with o_data=0x%0h, required no strobe",
                     rx_if.o_data);
         end else begin
            exp_m = exp_q.pop_front();
            check("rx_data", {24'd0, rx_if.o_data}, {24'd0, exp_m[7:0]});
            check("frame_err", {31'd0, rx_if.o_frame_err}, {31'd0, exp_m[8]});
         end
      end
      prev_done = rx_if.o_rx_done;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{data: 8'h55, stop_low: 0,  gap: 0, ferr: 1'b0};
      vecs[1] = '{data: 8'hA3, stop_low: 0,  gap: 0, ferr: 1'b0};
      vecs[2] = '{data: 8'h3C, stop_low: 0,  gap: 4, ferr: 1'b0};
      vecs[3] = '{data: 8'hFF, stop_low: 12, gap: 4, ferr: 1'b1};
      vecs[4] = '{data: 8'h12, stop_low: 0,  gap: 4, ferr: 1'b0};

      // reset
      #2 i_rst_n = 1'b0;
      repeat (5) @(posedge i_clk);
      #1;
      check("reset_data",  {24'd0, rx_if.o_data}, 32'd0);
      check("reset_done",  {31'd0, rx_if.o_rx_done}, 32'd0);
      check("reset_ferr",  {31'd0, rx_if.o_frame_err}, 32'd0);
      check("reset_busy",  {31'd0, rx_if.o_busy}, 32'd0);
      check("reset_state", {30'd0, rx_if.o_dbg_state}, {30'd0, ST_IDLE});
      i_rst_n = 1'b1;
      wait_ticks(2);
      #1;

      // table-driven frames
      for (int v = 0; v < 5; v++) begin
         exp_q.push_back({vecs[v].ferr, vecs[v].data});
         start_clk = clk_cnt;
         send_frame(vecs[v].data, vecs[v].stop_low);
         wait_ticks(vecs[v].gap);
         #1;
         check("frame_done_seen", exp_q.size(), 32'd0);
         check("busy_after_frame", {31'd0, rx_if.o_busy}, 32'd0);
         if (v == 0)
            check("done_latency", {31'd0, (done_clk - start_clk >= LAT_CLKS - 2) &&
                                          (done_clk - start_clk <= LAT_CLKS + 2)}, 32'd1);
      end

      // glitch: 4 ticks low is rejected at the mid-start check
      i_rx = 1'b0;
      wait_ticks(4);
      i_rx = 1'b1;
      wait_ticks(2);
      #1;
      check("glitch_busy_high", {31'd0, rx_if.o_busy}, 32'd1);
      wait_ticks(4);
      #1;
      check("glitch_busy_low", {31'd0, rx_if.o_busy}, 32'd0);
      check("glitch_state", {30'd0, rx_if.o_dbg_state}, {30'd0, ST_IDLE});
      check("glitch_data_kept", {24'd0, rx_if.o_data}, 32'h12);

      // reset during data bit 3 aborts the frame
      fork
         send_frame(8'h81, 0);
         begin
            wait_ticks(OS + 3 * OS + OS / 2);
            #1 i_rst_n = 1'b0;
            #1;
            check("midrst_data",  {24'd0, rx_if.o_data}, 32'd0);
            check("midrst_done",  {31'd0, rx_if.o_rx_done}, 32'd0);
            check("midrst_ferr",  {31'd0, rx_if.o_frame_err}, 32'd0);
            check("midrst_busy",  {31'd0, rx_if.o_busy}, 32'd0);
            check("midrst_state", {30'd0, rx_if.o_dbg_state}, {30'd0, ST_IDLE});
         end
      join
      wait_ticks(2);
      #1 i_rst_n = 1'b1;
      wait_ticks(2);
      #1;
      check("post_rst_data", {24'd0, rx_if.o_data}, 32'd0);
      exp_q.push_back({1'b0, 8'h81});
      send_frame(8'h81, 0);
      wait_ticks(2);
      #1;
      check("post_rst_frame_seen", exp_q.size(), 32'd0);
      check("post_rst_frame_data", {24'd0, rx_if.o_data}, 32'h81);

      // tick freeze mid-DATA
      exp_q.push_back({1'b0, 8'hC6});
      fork
         send_frame(8'hC6, 0);
         begin
            wait_ticks(60);
            #1 tick_en = 1'b0;
            repeat (5000) @(posedge i_clk);
            #1;
            check("freeze_state", {30'd0, rx_if.o_dbg_state}, {30'd0, ST_DATA});
            check("freeze_busy", {31'd0, rx_if.o_busy}, 32'd1);
            check("freeze_no_strobe", exp_q.size(), 32'd1);
            tick_en = 1'b1;
         end
      join
      wait_ticks(2);
      #1;
      check("freeze_frame_seen", exp_q.size(), 32'd0);
      check("freeze_frame_data", {24'd0, rx_if.o_data}, 32'hC6);

      // break: line low yields two all-zero frames with framing errors
      exp_q.push_back({1'b1, 8'h00});
      exp_q.push_back({1'b1, 8'h00});
      i_rx = 1'b0;
      wait_ticks(307);
      i_rx = 1'b1;
      wait_ticks(20);
      #1;
      check("break_frames_seen", exp_q.size(), 32'd0);
      check("break_busy", {31'd0, rx_if.o_busy}, 32'd0);
      check("break_ferr", {31'd0, rx_if.o_frame_err}, 32'd1);

      // clean frame clears the framing error
      exp_q.push_back({1'b0, 8'h5A});
      send_frame(8'h5A, 0);
      wait_ticks(2);
      #1;
      check("final_frame_seen", exp_q.size(), 32'd0);
      check("final_ferr_clear", {31'd0, rx_if.o_frame_err}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
